// File: rtl/counter_10bit.sv
// counter_10bit: free-running binary up-counter with a synchronous parallel load.
// The count wraps modulo 2^WIDTH with no flag and no stall. count_out is driven
// straight from the count register, so there is no combinational path from the inputs.
module counter_10bit #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_count_value,
    output logic [WIDTH-1:0] count_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    // Next-state selection: a load overrides the increment on the same edge.
    // The increment is truncated to WIDTH bits, which gives the silent wrap.
    always_comb begin
        count_next = count_reg + ONE;
        if (load) begin
            count_next = load_count_value;
        end
    end

    // Count register: the asynchronous reset dominates both load and increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= RESET_VALUE;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_out = count_reg;

endmodule

// File: tb/tb_counter_10bit.sv
// Directed bench for counter_10bit. The stimulus runs as one linear sequence.
// Every expected value is computed by hand or with simple modulo-1024 arithmetic.
module tb_counter_10bit;

    logic       clk;
    logic       rstn;
    logic       load;
    logic [9:0] load_count_value;
    logic [9:0] count_out;

    int checks   = 0;
    int failures = 0;

    counter_10bit #(
        .WIDTH      (10),
        .RESET_VALUE(10'd0)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .load            (load),
        .load_count_value(load_count_value),
        .count_out       (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [9:0] expected);
        checks++;
        assert (count_out === expected)
            $display("check %-16s count_out=%0d expected=%0d ok", tag, count_out, expected);
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, count_out, expected);
        end
    endtask

    initial begin
        int v;
        int n;
        logic [9:0] exp_val;

        rstn             = 1'b0;
        load             = 1'b0;
        load_count_value = 10'd0;

        // Reset state, then release rstn away from the clock edge.
        #12;
        check("reset_state", 10'd0);
        rstn = 1'b1;
        tick();
        check("post_release", 10'd1);

        // Reach 0x155, then assert reset mid-cycle. The value must clear with no edge.
        load = 1'b1; load_count_value = 10'h155;
        tick();
        check("load_0x155", 10'h155);
        load = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        check("async_clear", 10'd0);
        tick();
        tick();
        check("hold_in_reset", 10'd0);
        #3;
        rstn = 1'b1;
        tick(); check("release_1", 10'd1);
        tick(); check("release_2", 10'd2);
        tick(); check("release_3", 10'd3);

        // Load 300, then count 150 edges.
        load = 1'b1; load_count_value = 10'd300;
        tick();
        check("load_300", 10'd300);
        load = 1'b0;
        repeat (150) tick();
        check("count_to_450", 10'd450);

        // Wrap cases.
        load = 1'b1; load_count_value = 10'd1000;
        tick();
        load = 1'b0;
        repeat (150) tick();
        check("wrap_1000_150", 10'd126);
        load = 1'b1; load_count_value = 10'd1023;
        tick();
        check("load_1023", 10'd1023);
        load = 1'b0;
        tick();
        check("wrap_to_0", 10'd0);

        // Held load tracks the value. After release, counting continues.
        load = 1'b1; load_count_value = 10'd5;
        tick(); check("hold_load_5", 10'd5);
        load_count_value = 10'd9;
        tick(); check("hold_load_9", 10'd9);
        load_count_value = 10'd700;
        tick(); check("hold_load_700", 10'd700);
        load = 1'b0;
        tick(); check("after_hold_701", 10'd701);
        tick(); check("after_hold_702", 10'd702);
        load_count_value = 10'd33;
        tick(); check("value_ignored", 10'd703);

        // Randomised load-and-run regression.
        for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(0, 1023));
            n = int'($urandom_range(100, 200));
            load = 1'b1; load_count_value = v[9:0];
            tick();
            load = 1'b0;
            repeat (n) tick();
            exp_val = 10'((v + n) % 1024);
            $display("run %0d: load=%0d n=%0d", i, v, n);
            check($sformatf("rand_run_%0d", i), exp_val);
        end

        // Reset asserted in the cycle that presents a load.
        load = 1'b1; load_count_value = 10'd77;
        #2;
        rstn = 1'b0;
        #1;
        check("rst_during_load", 10'd0);
        tick();
        check("rst_beats_load", 10'd0);
        load = 1'b0;
        #3;
        rstn = 1'b1;
        tick();
        check("no_capture_77", 10'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
